// File: rtl/reg_defines.sv
// Shared register-level definitions: machine width, PC step and the fetch
// state encoding used by the PC generator.
package reg_defines;

  localparam int REG_WIDTH = 32;
  localparam int PC_INC    = 4;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Fetch request handshake between the PC generator (master) and the fetch unit.
interface pc_gen_if #(
  parameter int XLEN = reg_defines::REG_WIDTH
);

  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;

  modport master (output fetch_valid, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack: pushes overwrite the oldest entry when full,
// push+pop together replace the top, flush empties it before a same-cycle push.
module pc_ras
  import reg_defines::*;
#(
  parameter int XLEN      = REG_WIDTH,
  parameter int RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [XLEN-1:0]  mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] top_idx;
  logic             do_pop;

  // ptr_q is the next free slot, so the top lives one below it (mod depth).
  assign top_idx = ptr_q - PTR_W'(1);
  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(RAS_DEPTH));
  assign top     = mem[top_idx];
  assign do_pop  = pop && !empty && !flush;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      count_q <= '0;
    end else if (flush) begin
      count_q <= push ? CNT_W'(1) : '0;
      if (push) ptr_q <= ptr_q + PTR_W'(1);
    end else if (push && !do_pop) begin
      ptr_q <= ptr_q + PTR_W'(1);
      if (!full) count_q <= count_q + CNT_W'(1);
    end else if (do_pop && !push) begin
      ptr_q   <= top_idx;
      count_q <= count_q - CNT_W'(1);
    end
  end

  // NOTE: entry storage has no reset; count_q alone decides which slots are
  // meaningful, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clock) begin
    if (push) mem[do_pop ? top_idx : ptr_q] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: prioritised next-PC selection (trap, redirect,
// RAS return, sequential), RUN/HALT fetch control and misalignment flagging.
module pc_gen
  import reg_defines::*;
#(
  parameter int              XLEN      = REG_WIDTH,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h3000_0000),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  pc_gen_if.master        fetch,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            ras_push,
  input  logic            ras_pop,
  input  logic            halt_req,
  output logic            halted,
  output logic            misalign,
  output logic            ras_empty
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  logic [XLEN-1:0] target;
  logic            take_target;
  logic            handshake;
  logic            pop_eff;
  logic [XLEN-1:0] ras_top;
  logic [XLEN-1:0] pc_seq;

  assign pc_seq    = pc_q + XLEN'(PC_INC);
  assign handshake = (state_q == ST_RUN) && fetch.fetch_ready;
  // A RAS return only steers fetch while running and nothing outranks it.
  assign pop_eff   = (state_q == ST_RUN) && ras_pop && !trap_valid
                     && !redirect_valid && !ras_empty;

  pc_ras #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock     (clock),
    .reset     (reset),
    .flush     (trap_valid),
    .push      (ras_push),
    .pop       (pop_eff),
    .push_data (pc_seq),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      ()
  );

  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    target      = '0;
    take_target = 1'b0;

    if (trap_valid) begin
      target      = trap_vec;
      take_target = 1'b1;
    end else if (redirect_valid) begin
      target      = redirect_pc;
      take_target = 1'b1;
    end else if (pop_eff) begin
      target      = ras_top;
      take_target = 1'b1;
    end

    if (take_target) begin
      pc_d       = {target[XLEN-1:2], 2'b00};
      misalign_d = |target[1:0];
    end else if (handshake) begin
      pc_d = pc_seq;
    end

    unique case (state_q)
      ST_RUN:  if (halt_req && !handshake)     state_d = ST_HALT;
      ST_HALT: if (!halt_req || trap_valid)    state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch.fetch_valid = (state_q == ST_RUN);
  assign fetch.fetch_pc    = pc_q;
  assign halted            = (state_q == ST_HALT);
  assign misalign          = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed and randomized checks of pc_gen against a queue-based reference model.
module tb_pc_gen;
  import reg_defines::*;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RV    = 32'h3000_0000;
  localparam int          DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        redirect_valid, trap_valid, ras_push, ras_pop, halt_req;
  logic [31:0] redirect_pc, trap_vec;
  logic        halted, misalign, ras_empty;

  always #5 clock = ~clock;

  pc_gen_if #(.XLEN(XLEN)) fetch_bus ();

  pc_gen #(
    .XLEN      (XLEN),
    .RESET_VEC (RV),
    .RAS_DEPTH (DEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .fetch          (fetch_bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_vec       (trap_vec),
    .ras_push       (ras_push),
    .ras_pop        (ras_pop),
    .halt_req       (halt_req),
    .halted         (halted),
    .misalign       (misalign),
    .ras_empty      (ras_empty)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC, halt flag, pending misalign flag and
  // the return stack as a queue (back = top, front = oldest).
  logic [31:0] m_pc;
  bit          m_halt;
  bit          m_mis;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".pc"},     fetch_bus.fetch_pc,           m_pc);
    check({tag, ".valid"},  {31'd0, fetch_bus.fetch_valid}, {31'd0, !m_halt});
    check({tag, ".halted"}, {31'd0, halted},              {31'd0, m_halt});
    check({tag, ".mis"},    {31'd0, misalign},            {31'd0, m_mis});
    check({tag, ".empty"},  {31'd0, ras_empty},           {31'd0, m_ras.size() == 0});
  endtask

  task automatic model_next();
    bit          hs, pop_ok, take;
    logic [31:0] tgt;
    logic [31:0] seq;
    hs     = !m_halt && fetch_bus.fetch_ready;
    pop_ok = !m_halt && ras_pop && !trap_valid && !redirect_valid && m_ras.size() > 0;
    seq    = m_pc + 32'd4;
    take   = 1'b1;
    tgt    = 32'd0;
    if (trap_valid)          tgt = trap_vec;
    else if (redirect_valid) tgt = redirect_pc;
    else if (pop_ok)         tgt = m_ras[$];
    else                     take = 1'b0;

    m_mis = take && (tgt % 4 != 0);
    if (!m_halt) begin
      if (halt_req && !hs) m_halt = 1'b1;
    end else if (!halt_req || trap_valid) begin
      m_halt = 1'b0;
    end

    if (trap_valid) m_ras.delete();
    if (pop_ok)     void'(m_ras.pop_back());
    if (ras_push) begin
      m_ras.push_back(seq);
      if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
    end

    if (take)    m_pc = tgt - (tgt % 4);
    else if (hs) m_pc = seq;
  endtask

  task automatic step(input string tag);
    model_next();
    @(posedge clock);
    #1;
    compare_all(tag);
  endtask

  task automatic idle();
    fetch_bus.fetch_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    trap_vec       = '0;
    ras_push       = 1'b0;
    ras_pop        = 1'b0;
    halt_req       = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    m_pc   = RV;
    m_halt = 1'b0;
    m_mis  = 1'b0;
    m_ras.delete();
    #1;
    compare_all({tag, ".async"});
    @(negedge clock);
    reset = 1'b0;
    #1;
    compare_all({tag, ".rel"});
  endtask

  initial begin
    idle();
    do_reset("rst0");
    check("rst0.pc_const", fetch_bus.fetch_pc, 32'h3000_0000);

    // Sequential fetch from the reset vector.
    fetch_bus.fetch_ready = 1'b1;
    step("seq1"); check("seq1.c", fetch_bus.fetch_pc, 32'h3000_0004);
    step("seq2"); check("seq2.c", fetch_bus.fetch_pc, 32'h3000_0008);
    step("seq3"); check("seq3.c", fetch_bus.fetch_pc, 32'h3000_000C);

    // Load the RAS, then trap and redirect together: trap wins and flushes.
    idle(); ras_push = 1'b1;
    step("push0"); check("push0.empty", {31'd0, ras_empty}, 32'd0);
    idle();
    trap_valid = 1'b1; trap_vec = 32'h8000_0000;
    redirect_valid = 1'b1; redirect_pc = 32'h3000_0100;
    step("trap");
    check("trap.c", fetch_bus.fetch_pc, 32'h8000_0000);
    check("trap.empty", {31'd0, ras_empty}, 32'd1);

    // Misaligned redirect: low bits dropped, one-cycle misalign pulse.
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h3000_0102;
    step("mis");
    check("mis.c", fetch_bus.fetch_pc, 32'h3000_0100);
    check("mis.pulse", {31'd0, misalign}, 32'd1);
    idle();
    step("mis_end"); check("mis_end.c", {31'd0, misalign}, 32'd0);

    // Five calls at A..E (3000_0100..0110) overflow a 4-deep stack.
    idle(); fetch_bus.fetch_ready = 1'b1; ras_push = 1'b1;
    for (int i = 0; i < 5; i++) step("call");
    check("call.pc", fetch_bus.fetch_pc, 32'h3000_0114);
    idle(); ras_pop = 1'b1;
    step("ret1"); check("ret1.c", fetch_bus.fetch_pc, 32'h3000_0114);
    step("ret2"); check("ret2.c", fetch_bus.fetch_pc, 32'h3000_0110);
    step("ret3"); check("ret3.c", fetch_bus.fetch_pc, 32'h3000_010C);
    step("ret4"); check("ret4.c", fetch_bus.fetch_pc, 32'h3000_0108);
    check("ret4.empty", {31'd0, ras_empty}, 32'd1);
    step("ret5"); check("ret5.c", fetch_bus.fetch_pc, 32'h3000_0108);

    // Halt request while a handshake is in flight.
    idle(); redirect_valid = 1'b1; redirect_pc = 32'h3000_0010;
    step("hredir");
    idle(); halt_req = 1'b1; fetch_bus.fetch_ready = 1'b1;
    step("hhs");
    check("hhs.c", fetch_bus.fetch_pc, 32'h3000_0014);
    check("hhs.halted", {31'd0, halted}, 32'd0);
    fetch_bus.fetch_ready = 1'b0;
    step("hent");
    check("hent.halted", {31'd0, halted}, 32'd1);
    check("hent.valid", {31'd0, fetch_bus.fetch_valid}, 32'd0);
    halt_req = 1'b0;
    step("hexit");
    check("hexit.halted", {31'd0, halted}, 32'd0);
    check("hexit.c", fetch_bus.fetch_pc, 32'h3000_0014);

    // Wrap at the top of the address space.
    idle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step("wredir");
    idle(); fetch_bus.fetch_ready = 1'b1;
    step("wrap"); check("wrap.c", fetch_bus.fetch_pc, 32'h0000_0000);

    // Randomized traffic with sticky halt requests and occasional resets.
    idle();
    for (int n = 0; n < 600; n++) begin
      fetch_bus.fetch_ready = ($urandom_range(1) == 1);
      trap_valid     = ($urandom_range(15) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      ras_push       = ($urandom_range(3) == 0);
      ras_pop        = ($urandom_range(2) == 0);
      trap_vec       = $urandom;
      redirect_pc    = $urandom;
      if ($urandom_range(2) != 0) begin
        trap_vec[1:0]    = 2'b00;
        redirect_pc[1:0] = 2'b00;
      end
      if ($urandom_range(9) == 0) halt_req = !halt_req;
      if ($urandom_range(149) == 0) begin
        halt_req = 1'b1;
        do_reset("rnd.rst");
      end else begin
        step("rnd");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
